// File: rtl/decode_stage.sv
// Instruction-decode stage of the pipelined RV32I core.
//
// Holds the register file, decodes the IF_ID instruction into the control
// bundle and immediate latched by ID_EX, and detects load-use hazards.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   instr, pc, pcAdd4   IF_ID contents; pc/pcAdd4 pass through to pcOut/pcAdd4Out
//   flush               taken branch/jump from EX; kills controls and stall
//   exRd, exLw          destination and load flag of the instruction in ID_EX
//   wbEn, wbRd, wbData  register-file write port from writeback
//   rs1, rs2            register read data (with writeback bypass)
//   imm, rd             sign-extended immediate, destination index
//   EscReg .. lw        control bits
//   aluControl          000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
//   stall               load-use hazard: hold PC/IF_ID, bubble ID_EX
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcAdd4,
  input  logic            flush,
  input  logic [4:0]      exRd,
  input  logic            exLw,
  input  logic            wbEn,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcAdd4Out,
  output logic [4:0]      rd,
  output logic            EscReg,
  output logic            EscMem,
  output logic            ulaImm,
  output logic            jump,
  output logic            Branch,
  output logic            lui,
  output logic            auiPc,
  output logic            jalr,
  output logic            lw,
  output logic [2:0]      aluControl,
  output logic            stall
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSll = 3'b110;
  localparam logic [2:0] AluSrl = 3'b111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];

  // x0 is only ever cleared; reads of index 0 are forced to zero as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wbEn && (wbRd != 5'd0)) begin
      regs_q[wbRd] <= wbData;
    end
  end

  logic [XLEN-1:0] rs1_raw;
  logic [XLEN-1:0] rs2_raw;

  // Write-through bypass so a same-cycle writeback is visible to decode.
  always_comb begin
    rs1_raw = '0;
    rs2_raw = '0;
    if (rs1_idx != 5'd0) begin
      rs1_raw = (wbEn && (wbRd == rs1_idx)) ? wbData : regs_q[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      rs2_raw = (wbEn && (wbRd == rs2_idx)) ? wbData : regs_q[rs2_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Immediates
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;

  assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic            esc_reg_d;
  logic            esc_mem_d;
  logic            ula_imm_d;
  logic            jump_d;
  logic            branch_d;
  logic            lui_d;
  logic            auipc_d;
  logic            jalr_d;
  logic            lw_d;
  logic [2:0]      alu_d;
  logic [XLEN-1:0] imm_d;
  logic            uses_rs1;
  logic            uses_rs2;

  always_comb begin
    esc_reg_d = 1'b0;
    esc_mem_d = 1'b0;
    ula_imm_d = 1'b0;
    jump_d    = 1'b0;
    branch_d  = 1'b0;
    lui_d     = 1'b0;
    auipc_d   = 1'b0;
    jalr_d    = 1'b0;
    lw_d      = 1'b0;
    alu_d     = AluAdd;
    imm_d     = '0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;

    case (opcode)
      OpR: begin
        esc_reg_d = 1'b1;
        uses_rs2  = 1'b1;
        case (funct3)
          3'b000:  alu_d = instr[30] ? AluSub : AluAdd;
          3'b111:  alu_d = AluAnd;
          3'b110:  alu_d = AluOr;
          3'b100:  alu_d = AluXor;
          3'b010:  alu_d = AluSlt;
          3'b001:  alu_d = AluSll;
          3'b101:  alu_d = AluSrl;
          default: alu_d = AluAdd;
        endcase
      end
      OpIAlu: begin
        esc_reg_d = 1'b1;
        ula_imm_d = 1'b1;
        imm_d     = imm_i;
        // No subtract form for immediates; funct3 selects the operation.
        case (funct3)
          3'b111:  alu_d = AluAnd;
          3'b110:  alu_d = AluOr;
          3'b100:  alu_d = AluXor;
          3'b010:  alu_d = AluSlt;
          3'b001:  alu_d = AluSll;
          3'b101:  alu_d = AluSrl;
          default: alu_d = AluAdd;
        endcase
      end
      OpLoad: begin
        esc_reg_d = 1'b1;
        ula_imm_d = 1'b1;
        lw_d      = 1'b1;
        imm_d     = imm_i;
      end
      OpStore: begin
        esc_mem_d = 1'b1;
        ula_imm_d = 1'b1;
        uses_rs2  = 1'b1;
        imm_d     = imm_s;
      end
      OpBeq: begin
        branch_d = 1'b1;
        uses_rs2 = 1'b1;
        alu_d    = AluSub;
        imm_d    = imm_b;
      end
      OpJal: begin
        esc_reg_d = 1'b1;
        jump_d    = 1'b1;
        uses_rs1  = 1'b0;
        imm_d     = imm_j;
      end
      OpJalr: begin
        esc_reg_d = 1'b1;
        jalr_d    = 1'b1;
        ula_imm_d = 1'b1;
        imm_d     = imm_i;
      end
      OpLui: begin
        esc_reg_d = 1'b1;
        lui_d     = 1'b1;
        uses_rs1  = 1'b0;
        imm_d     = imm_u;
      end
      OpAuipc: begin
        esc_reg_d = 1'b1;
        auipc_d   = 1'b1;
        uses_rs1  = 1'b0;
        imm_d     = imm_u;
      end
      default: begin
        // Unknown opcode decodes as a NOP.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard
  // ---------------------------------------------------------------------------
  logic hazard;

  assign hazard = exLw && (exRd != 5'd0) &&
                  ((uses_rs1 && (exRd == rs1_idx)) || (uses_rs2 && (exRd == rs2_idx)));

  // ---------------------------------------------------------------------------
  // Output gating: reset zeroes everything, flush zeroes controls and stall only.
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1        = '0;
    rs2        = '0;
    imm        = '0;
    pcOut      = '0;
    pcAdd4Out  = '0;
    rd         = '0;
    EscReg     = 1'b0;
    EscMem     = 1'b0;
    ulaImm     = 1'b0;
    jump       = 1'b0;
    Branch     = 1'b0;
    lui        = 1'b0;
    auiPc      = 1'b0;
    jalr       = 1'b0;
    lw         = 1'b0;
    aluControl = 3'b000;
    stall      = 1'b0;

    if (!reset) begin
      rs1       = rs1_raw;
      rs2       = rs2_raw;
      imm       = imm_d;
      pcOut     = pc;
      pcAdd4Out = pcAdd4;
      rd        = instr[11:7];
      if (!flush) begin
        EscReg     = esc_reg_d;
        EscMem     = esc_mem_d;
        ulaImm     = ula_imm_d;
        jump       = jump_d;
        Branch     = branch_d;
        lui        = lui_d;
        auiPc      = auipc_d;
        jalr       = jalr_d;
        lw         = lw_d;
        aluControl = alu_d;
        stall      = hazard;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-computed expected
// outputs into a queue; a monitor pops and compares on the falling edge.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcAdd4;
  logic        flush;
  logic [4:0]  exRd;
  logic        exLw;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [31:0] pcOut;
  logic [31:0] pcAdd4Out;
  logic [4:0]  rd;
  logic        EscReg, EscMem, ulaImm, jump, Branch, lui, auiPc, jalr, lw;
  logic [2:0]  aluControl;
  logic        stall;

  decode_stage #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .pc         (pc),
    .pcAdd4     (pcAdd4),
    .flush      (flush),
    .exRd       (exRd),
    .exLw       (exLw),
    .wbEn       (wbEn),
    .wbRd       (wbRd),
    .wbData     (wbData),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .pcOut      (pcOut),
    .pcAdd4Out  (pcAdd4Out),
    .rd         (rd),
    .EscReg     (EscReg),
    .EscMem     (EscMem),
    .ulaImm     (ulaImm),
    .jump       (jump),
    .Branch     (Branch),
    .lui        (lui),
    .auiPc      (auiPc),
    .jalr       (jalr),
    .lw         (lw),
    .aluControl (aluControl),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl packing: {EscReg, EscMem, ulaImm, jump, Branch, lui, auiPc, jalr, lw}
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
    logic [2:0]  alu;
    logic        stall;
  } out_t;

  typedef struct {
    string name;
    out_t  o;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] pc_v   = 32'h0000_1000;

  function automatic out_t mk(input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] im, input logic [4:0] d,
                              input logic [8:0] c, input logic [2:0] a, input logic s);
    out_t o;
    o.rs1   = r1;
    o.rs2   = r2;
    o.imm   = im;
    o.pc_o  = '0;
    o.pc4_o = '0;
    o.rd    = d;
    o.ctrl  = c;
    o.alu   = a;
    o.stall = s;
    return o;
  endfunction

  task automatic vec(input string name, input logic rst, input logic [31:0] ins,
                     input logic fl, input logic [4:0] erd, input logic elw,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                     input out_t exp);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = rst;
    instr  = ins;
    flush  = fl;
    exRd   = erd;
    exLw   = elw;
    wbEn   = we;
    wbRd   = wrd;
    wbData = wd;
    pc     = pc_v;
    pcAdd4 = pc_v + 32'd4;
    e.name = name;
    e.o    = exp;
    if (!rst) begin
      e.o.pc_o  = pc_v;
      e.o.pc4_o = pc_v + 32'd4;
    end
    exp_q.push_back(e);
    pc_v = pc_v + 32'd4;
  endtask

  // Monitor: outputs are combinational, so every vector is presented for one
  // cycle and checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      out_t got;
      e         = exp_q.pop_front();
      got.rs1   = rs1;
      got.rs2   = rs2;
      got.imm   = imm;
      got.pc_o  = pcOut;
      got.pc4_o = pcAdd4Out;
      got.rd    = rd;
      got.ctrl  = {EscReg, EscMem, ulaImm, jump, Branch, lui, auiPc, jalr, lw};
      got.alu   = aluControl;
      got.stall = stall;
      n_vec++;
      if (got !== e.o) begin
        n_fail++;
        $display("FAIL %s: got rs1=%h rs2=%h imm=%h pc=%h pc4=%h rd=%0d ctrl=%h alu=%0d stall=%b | want rs1=%h rs2=%h imm=%h pc=%h pc4=%h rd=%0d ctrl=%h alu=%0d stall=%b",
                 e.name, got.rs1, got.rs2, got.imm, got.pc_o, got.pc4_o, got.rd, got.ctrl,
                 got.alu, got.stall, e.o.rs1, e.o.rs2, e.o.imm, e.o.pc_o, e.o.pc4_o, e.o.rd,
                 e.o.ctrl, e.o.alu, e.o.stall);
      end
    end
  end

  localparam logic [31:0] IllegalOp = 32'h0000_007F;
  localparam logic [31:0] AddX11X5  = 32'h0002_85B3;  // add x11, x5, x0
  localparam logic [31:0] AddX11X0  = 32'h0000_05B3;  // add x11, x0, x0
  localparam logic [31:0] AddX11X7  = 32'h0003_85B3;  // add x11, x7, x0
  localparam logic [31:0] Addi      = 32'hFFC5_0513;  // addi x10, x10, -4
  localparam logic [31:0] Sw        = 32'h00A1_2023;  // sw x10, 0(x2)
  localparam logic [31:0] AddLu     = 32'h00C5_05B3;  // add x11, x10, x12
  localparam logic [31:0] LuiX10    = 32'h0005_0537;  // lui x10, 0x50 (rs1 field = 10)
  localparam logic [31:0] Beq       = 32'h00C5_0463;  // beq x10, x12, +8
  localparam logic [31:0] Jal       = 32'hFFDF_F0EF;  // jal x1, -4
  localparam logic [31:0] Sub       = 32'h40C5_01B3;  // sub x3, x10, x12

  initial begin
    reset  = 1'b1;
    instr  = '0;
    pc     = '0;
    pcAdd4 = '0;
    flush  = 1'b0;
    exRd   = '0;
    exLw   = 1'b0;
    wbEn   = 1'b0;
    wbRd   = '0;
    wbData = '0;

    //   name            rst ins        fl exRd   lw we wbRd   wbData
    vec("reset_zero",    1, Addi,      0, 5'd10, 1, 1, 5'd5,  32'h1,
        mk(0, 0, 0, 0, 9'h000, 3'd0, 0));
    vec("illegal_wr_x5", 0, IllegalOp, 0, 5'd0,  0, 1, 5'd5,  32'h1234,
        mk(0, 0, 0, 0, 9'h000, 3'd0, 0));
    vec("read_x5",       0, AddX11X5,  0, 5'd0,  0, 0, 5'd0,  32'h0,
        mk(32'h1234, 0, 0, 11, 9'h100, 3'd0, 0));
    vec("reset_mid",     1, AddX11X5,  0, 5'd5,  1, 1, 5'd5,  32'h9999,
        mk(0, 0, 0, 0, 9'h000, 3'd0, 0));
    vec("x5_cleared",    0, AddX11X5,  0, 5'd0,  0, 0, 5'd0,  32'h0,
        mk(0, 0, 0, 11, 9'h100, 3'd0, 0));
    vec("x0_write",      0, IllegalOp, 0, 5'd0,  0, 1, 5'd0,  32'hFFFF_FFFF,
        mk(0, 0, 0, 0, 9'h000, 3'd0, 0));
    vec("x0_read",       0, AddX11X0,  0, 5'd0,  0, 0, 5'd0,  32'h0,
        mk(0, 0, 0, 11, 9'h100, 3'd0, 0));
    vec("bypass_x7",     0, AddX11X7,  0, 5'd0,  0, 1, 5'd7,  32'hDEAD_BEEF,
        mk(32'hDEAD_BEEF, 0, 0, 11, 9'h100, 3'd0, 0));
    vec("stored_x7",     0, AddX11X7,  0, 5'd0,  0, 0, 5'd0,  32'h0,
        mk(32'hDEAD_BEEF, 0, 0, 11, 9'h100, 3'd0, 0));
    vec("addi",          0, Addi,      0, 5'd0,  0, 1, 5'd10, 32'h10,
        mk(32'h10, 0, 32'hFFFF_FFFC, 10, 9'h140, 3'd0, 0));
    vec("sw",            0, Sw,        0, 5'd0,  0, 1, 5'd12, 32'h5,
        mk(0, 32'h10, 0, 0, 9'h0C0, 3'd0, 0));
    vec("loaduse_stall", 0, AddLu,     0, 5'd10, 1, 0, 5'd0,  32'h0,
        mk(32'h10, 32'h5, 0, 11, 9'h100, 3'd0, 1));
    vec("loaduse_x0",    0, AddLu,     0, 5'd0,  1, 0, 5'd0,  32'h0,
        mk(32'h10, 32'h5, 0, 11, 9'h100, 3'd0, 0));
    vec("lui_no_stall",  0, LuiX10,    0, 5'd10, 1, 0, 5'd0,  32'h0,
        mk(32'h10, 0, 32'h0005_0000, 10, 9'h108, 3'd0, 0));
    vec("flush_hazard",  0, AddLu,     1, 5'd10, 1, 0, 5'd0,  32'h0,
        mk(32'h10, 32'h5, 0, 11, 9'h000, 3'd0, 0));
    vec("illegal_op",    0, IllegalOp, 0, 5'd0,  1, 0, 5'd0,  32'h0,
        mk(0, 0, 0, 0, 9'h000, 3'd0, 0));
    vec("beq_rs2_stall", 0, Beq,       0, 5'd12, 1, 0, 5'd0,  32'h0,
        mk(32'h10, 32'h5, 32'h8, 8, 9'h010, 3'd1, 1));
    vec("jal_no_rs1",    0, Jal,       0, 5'd31, 1, 0, 5'd0,  32'h0,
        mk(0, 0, 32'hFFFF_FFFC, 1, 9'h120, 3'd0, 0));
    vec("sub",           0, Sub,       0, 5'd0,  0, 0, 5'd0,  32'h0,
        mk(32'h10, 32'h5, 0, 3, 9'h100, 3'd1, 0));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d vectors unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the pipelined RV32I core. It holds the 32×32 register file, decodes the instruction from IF_ID into the control bundle and immediate that the ID_EX register latches, and detects load-use hazards. On a load-use hazard it raises `stall`, which holds PC and IF_ID and inserts a bubble into ID_EX. Writeback writes the register file through a dedicated port.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.
- `NREGS`, default 32: register count. x0 is hardwired to zero.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  **synchronous, active-high** reset.
- `instr`  in  32  instruction from IF_ID.
- `pc`, `pcAdd4`  in  32 each  from IF_ID; passed through unchanged to `pcOut` and `pcAdd4Out`.
- `flush`  in  1  taken branch or jump resolved in EX; kills the current decode.
- `exRd`  in  5  `rdOut` of ID_EX.
- `exLw`  in  1  `lwOut` of ID_EX.
- `wbEn`  in  1  writeback enable.
- `wbRd`  in  5  writeback register index.
- `wbData`  in  32  writeback value.
- `rs1`, `rs2`  out  32 each  register read data.
- `imm`  out  32  sign-extended immediate.
- `pcOut`, `pcAdd4Out`  out  32 each  passthrough of `pc` and `pcAdd4`.
- `rd`  out  5  destination register = `instr[11:7]`.
- `EscReg`, `EscMem`, `ulaImm`, `jump`, `Branch`, `lui`, `auiPc`, `jalr`, `lw`  out  1 each  control bits.
- `aluControl`  out  3  ALU operation code.
- `stall`  out  1  load-use hazard.

## Operation
- Register file:
  - On the rising edge with `wbEn && wbRd != 0`, write `wbData` to `reg[wbRd]`. Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational with write-through bypass: when `wbEn && wbRd == rsX && rsX != 0`, `rsX` returns `wbData` in the same cycle.
- aluControl encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- Decode by opcode:
  - R-type (0110011): `EscReg`; ALU op from funct3/funct7 (add/sub/and/or/xor/slt/sll/srl).
  - I-ALU (0010011): `EscReg`, `ulaImm`; I-immediate.
  - lw (0000011): `EscReg`, `ulaImm`, `lw`; add.
  - sw (0100011): `EscMem`, `ulaImm`; S-immediate; add.
  - beq (1100011): `Branch`; B-immediate; sub.
  - jal (1101111): `EscReg`, `jump`; J-immediate.
  - jalr (1100111): `EscReg`, `jalr`, `ulaImm`; I-immediate; add.
  - lui (0110111): `EscReg`, `lui`; U-immediate.
  - auipc (0010111): `EscReg`, `auiPc`; U-immediate.
  - Any other opcode: all controls 0 (NOP), `imm` = 0.
- Immediates follow the RV32I I/S/B/J formats, sign-extended from `instr[31]`. The U-format immediate is `{instr[31:12], 12'b0}`.
- Hazard: `stall = exLw && exRd != 0 && (exRd == instr[19:15] || (usesRs2 && exRd == instr[24:20]))`.
  - `usesRs2` is true for R-type, sw, and beq.
  - rs1 is treated as used for every opcode except lui, auipc, and jal.
- Precedence:
  - `reset` overrides everything.
  - `flush` overrides `stall`: it forces all control outputs, `aluControl`, and `stall` to 0.
  - Data outputs are unaffected by `flush`.

## Timing
- Decode, immediate generation, register reads, and `stall` are combinational from inputs and current register state: zero-cycle latency.
- A register write becomes visible to reads in the same cycle (bypass) and from storage on every later cycle.
- Reset:
  - While `reset` is high, all outputs are 0 (controls, `aluControl`, `stall`, `rs1`, `rs2`, `imm`, `rd`, `pcOut`, `pcAdd4Out`).
  - On the rising edge with `reset` high, all 32 registers clear to 0; a `wbEn` write in that cycle is discarded.
  - Reset in the middle of a stall drops `stall` immediately.
- A load-use stall lasts exactly one cycle: after the bubble, `exLw` is 0, so `stall` deasserts with no internal counter.
- Simultaneous writeback and read of the same register: the read returns `wbData`.
- Simultaneous `flush` and `stall` condition: `stall` = 0.

## Test plan
- Reset:
  - Write x5 = 0x1234.
  - Assert `reset` for one edge.
  - Read x5 → 0.
  - All outputs are 0 while reset is high.
- Register file:
  - Write x0 = 0xFFFF_FFFF, then read x0 → 0.
  - Write x7 = 0xDEAD_BEEF with `instr` reading rs1 = x7 in the same cycle → `rs1` = 0xDEAD_BEEF before the edge.
- Decode:
  - `instr` = 0xFFC50513 (addi x10, x10, -4) → `EscReg` = 1, `ulaImm` = 1, `aluControl` = 000, `imm` = 0xFFFF_FFFC, `rd` = 10.
  - `instr` = 0x00A12023 (sw x10, 0(x2)) → `EscMem` = 1, `EscReg` = 0, `imm` = 0.
- Load-use:
  - `exLw` = 1, `exRd` = 10, `instr` = add x11, x10, x12 → `stall` = 1.
  - Same with `exRd` = 0 → `stall` = 0.
  - Same with `instr` = lui x10 → `stall` = 0.
- Flush: with the same hazard active, `flush` = 1 → `stall` = 0 and all controls = 0, while `rs1`/`rs2` still reflect register contents.
- Illegal opcode: `instr` = 0x0000007F → all controls, `aluControl`, and `imm` = 0.
